// File: rtl/half_subtractor_pkg.sv
// Shared definitions for the half subtractor family: default sizing
// constants and the single-lane subtract function, which a future
// full subtractor can reuse directly.
package half_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // Result of subtracting one bit from another: difference and borrow-out.
  typedef struct packed {
    logic borrow;
    logic diff;
  } laneResult_t;

  // One-bit half subtraction a - b. X/Z on the inputs propagate through
  // the plain operators; nothing is masked.
  function automatic laneResult_t halfSub(input logic a, input logic b);
    laneResult_t res;
    res.diff   = a ^ b;
    res.borrow = ~a & b;
    return res;
  endfunction

endpackage

// File: rtl/half_subtractor_lane.sv
// Single-bit combinational half subtractor cell. Purely combinational,
// no clock or reset; the top replicates it once per lane.
module half_subtractor_lane
  import half_subtractor_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic d_o,
  output logic borrow_o
);

  laneResult_t res;

  // Evaluate the shared lane function and split it onto the outputs.
  always_comb begin
    res      = halfSub(a_i, b_i);
    d_o      = res.diff;
    borrow_o = res.borrow;
  end

endmodule

// File: rtl/half_subtractor.sv
// Bitwise half subtractor: WIDTH independent lanes with combinational
// outputs plus a one-cycle registered copy qualified by out_valid.
// Optional feature macro: HALF_SUB_BORROW_CNT_EN adds a saturating
// counter (borrow_cnt) of accepted inputs that produced any borrow.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] borrow_q,
`ifdef HALF_SUB_BORROW_CNT_EN
  output logic [CNT_W-1:0] borrow_cnt,
`endif
  output logic             out_valid
);

  // Both widths must describe at least one bit.
  if (WIDTH < 1 || CNT_W < 1) begin : gBadParam
    $error("half_subtractor: WIDTH and CNT_W must be at least 1");
  end

  // One combinational cell per lane; lanes never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : gLane
    half_subtractor_lane uLane (
      .a_i      (a[i]),
      .b_i      (b[i]),
      .d_o      (d[i]),
      .borrow_o (borrow[i])
    );
  end

  logic [WIDTH-1:0] diff_d, diff_q;
  logic [WIDTH-1:0] brw_d, brw_q;
  logic             valid_d, valid_q;

  // Capture the combinational result on a valid input; otherwise hold
  // the data and drop the valid flag.
  always_comb begin
    diff_d  = diff_q;
    brw_d   = brw_q;
    valid_d = 1'b0;
    if (in_valid) begin
      diff_d  = d;
      brw_d   = borrow;
      valid_d = 1'b1;
    end
  end

  // Output registers, cleared immediately whenever reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q  <= '0;
      brw_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      valid_q <= valid_d;
    end
  end

  assign d_q       = diff_q;
  assign borrow_q  = brw_q;
  assign out_valid = valid_q;

`ifdef HALF_SUB_BORROW_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count accepted inputs where any lane borrowed, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|borrow) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor: a 1-lane and a 4-lane instance,
// directed checks of the truth table, registered path, async reset and
// the optional borrow counter, plus randomized traffic against a model
// that treats each lane as a 2-bit arithmetic subtraction.
module tb_half_subtractor;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, inValid1;
  logic       d1, borrow1, dQ1, borrowQ1, outValid1;
  logic [3:0] a4, b4;
  logic       inValid4;
  logic [3:0] d4, borrow4, dQ4, borrowQ4;
  logic       outValid4;
`ifdef HALF_SUB_BORROW_CNT_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt4;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  half_subtractor #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a1),
    .b          (b1),
    .in_valid   (inValid1),
    .d          (d1),
    .borrow     (borrow1),
    .d_q        (dQ1),
    .borrow_q   (borrowQ1),
`ifdef HALF_SUB_BORROW_CNT_EN
    .borrow_cnt (cnt1),
`endif
    .out_valid  (outValid1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a4),
    .b          (b4),
    .in_valid   (inValid4),
    .d          (d4),
    .borrow     (borrow4),
    .d_q        (dQ4),
    .borrow_q   (borrowQ4),
`ifdef HALF_SUB_BORROW_CNT_EN
    .borrow_cnt (cnt4),
`endif
    .out_valid  (outValid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] aIn, input logic [3:0] bIn,
                               input logic vIn);
    a4       = aIn;
    b4       = bIn;
    inValid4 = vIn;
  endtask

  // Reference: each lane computes (a - b) mod 4 as an integer; bit 0 is
  // the difference and bit 1 is the borrow. Returns {borrow, diff}.
  function automatic logic [7:0] refSub(input logic [3:0] aIn, input logic [3:0] bIn);
    logic [3:0] dRef, bRef;
    int         diff;
    for (int i = 0; i < 4; i++) begin
      diff    = (int'(aIn[i]) - int'(bIn[i])) & 3;
      dRef[i] = diff[0];
      bRef[i] = diff[1];
    end
    return {bRef, dRef};
  endfunction

  logic [7:0] r;
  logic [3:0] expD4, expB4;
  logic       expV4;
  int         expCnt4;
  int         expCnt1;
  logic [1:0] pat;

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; inValid1 = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0);
    expCnt4 = 0;
    expCnt1 = 0;
    #12;
    checkOutput("rst_dq1", {31'b0, dQ1}, 0);
    checkOutput("rst_bq1", {31'b0, borrowQ1}, 0);
    checkOutput("rst_ov1", {31'b0, outValid1}, 0);
    checkOutput("rst_dq4", {28'b0, dQ4}, 0);
    checkOutput("rst_ov4", {31'b0, outValid4}, 0);

    // Truth table on the 1-lane instance while reset is still held.
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      a1 = pat[1];
      b1 = pat[0];
      #40;
      r = refSub({3'b0, a1}, {3'b0, b1});
      checkOutput("tt_d", {31'b0, d1}, {31'b0, r[0]});
      checkOutput("tt_borrow", {31'b0, borrow1}, {31'b0, r[4]});
      #10;
    end
    checkOutput("tt_dq_in_reset", {31'b0, dQ1}, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path on the 1-lane instance.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; inValid1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("reg_dq", {31'b0, dQ1}, 1);
    checkOutput("reg_bq", {31'b0, borrowQ1}, 0);
    checkOutput("reg_ov", {31'b0, outValid1}, 1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; inValid1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold_ov", {31'b0, outValid1}, 0);
    checkOutput("hold_dq", {31'b0, dQ1}, 1);
    checkOutput("hold_bq", {31'b0, borrowQ1}, 0);
    checkOutput("hold_comb_d", {31'b0, d1}, 1);
    checkOutput("hold_comb_b", {31'b0, borrow1}, 1);

    // Four-lane directed vector.
    @(negedge clk);
    applyStimulus(4'b1010, 4'b0110, 1'b1);
    #1;
    checkOutput("w4_d", {28'b0, d4}, 32'b1100);
    checkOutput("w4_borrow", {28'b0, borrow4}, 32'b0100);
    @(posedge clk); #1;
    checkOutput("w4_dq", {28'b0, dQ4}, 32'b1100);
    checkOutput("w4_bq", {28'b0, borrowQ4}, 32'b0100);
    checkOutput("w4_ov", {31'b0, outValid4}, 1);
    expD4 = 4'b1100;
    expB4 = 4'b0100;
    expV4 = 1'b1;
    expCnt4 = 1;

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      applyStimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
      #1;
      r = refSub(a4, b4);
      checkOutput("rnd_d", {28'b0, d4}, {28'b0, r[3:0]});
      checkOutput("rnd_borrow", {28'b0, borrow4}, {28'b0, r[7:4]});
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("arst_dq", {28'b0, dQ4}, 0);
        checkOutput("arst_bq", {28'b0, borrowQ4}, 0);
        checkOutput("arst_ov", {31'b0, outValid4}, 0);
        checkOutput("arst_comb_d", {28'b0, d4}, {28'b0, r[3:0]});
        checkOutput("arst_comb_b", {28'b0, borrow4}, {28'b0, r[7:4]});
        expD4 = 4'h0; expB4 = 4'h0; expV4 = 1'b0; expCnt4 = 0;
        #1;
        rst_n = 1'b1;
      end
      @(posedge clk);
      if (inValid4) begin
        expD4 = r[3:0];
        expB4 = r[7:4];
        expV4 = 1'b1;
        if (r[7:4] != 4'h0 && expCnt4 < 65535) expCnt4++;
      end else begin
        expV4 = 1'b0;
      end
      #1;
      checkOutput("rnd_dq", {28'b0, dQ4}, {28'b0, expD4});
      checkOutput("rnd_bq", {28'b0, borrowQ4}, {28'b0, expB4});
      checkOutput("rnd_ov", {31'b0, outValid4}, {31'b0, expV4});
`ifdef HALF_SUB_BORROW_CNT_EN
      checkOutput("rnd_cnt", {16'b0, cnt4}, 32'(expCnt4));
`endif
    end

`ifdef HALF_SUB_BORROW_CNT_EN
    // Saturating counter on the 1-lane instance (2-bit counter).
    @(negedge clk);
    inValid1 = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("cnt_rst", {30'b0, cnt1}, 0);
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; inValid1 = 1'b1;
    expCnt1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      expCnt1 = (expCnt1 == 3) ? 3 : expCnt1 + 1;
      checkOutput("cnt_sat", {30'b0, cnt1}, 32'(expCnt1));
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("cnt_noborrow", {30'b0, cnt1}, 32'(expCnt1));
    @(negedge clk);
    inValid1 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
Name: half_subtractor

Overview:
- Bitwise half subtractor: difference d = a XOR b, borrow = (NOT a) AND b.
- Provides combinational outputs for glue logic, plus a registered copy with a valid qualifier for pipelined datapaths.
- Leaf arithmetic cell in the combinational-arithmetic library; a building block for full subtractors and ripple-borrow chains.

Parameters:
- WIDTH, 1, number of independent bit lanes (each lane is one half subtractor).
- CNT_W, 16, width of the borrow event counter (optional feature only).

Ports:
- clk  input  1  single clock for all registered logic.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  minuend bits.
- b  input  WIDTH  subtrahend bits.
- in_valid  input  1  qualifies a/b for the registered path.
- d  output  WIDTH  combinational difference, a ^ b.
- borrow  output  WIDTH  combinational borrow, ~a & b.
- d_q  output  WIDTH  registered difference.
- borrow_q  output  WIDTH  registered borrow.
- out_valid  output  1  d_q/borrow_q hold a result captured on the previous cycle.

Behaviour:
- d and borrow are purely combinational. They follow a/b with no clock dependency and are valid whether or not clk toggles or rst_n is asserted.
- Per-lane truth table (a,b -> d,borrow):
  - 0,0 -> 0,0
  - 0,1 -> 1,1
  - 1,0 -> 1,0
  - 1,1 -> 0,0
- Lanes are fully independent. There is no borrow propagation between bits.
- Registered path, 1-cycle latency: on a rising clk edge with in_valid=1, d_q<=a^b, borrow_q<=~a&b, and out_valid<=1.
- With in_valid=0 at the edge: d_q and borrow_q hold their previous value, and out_valid<=0.
- No backpressure. Every valid input is accepted, and back-to-back valids give back-to-back results.
- Reset: rst_n=0 immediately (asynchronously) clears d_q, borrow_q and out_valid to 0. The combinational outputs are unaffected.
- Reset deassertion is sampled synchronously. The first capture can occur on the first rising edge with rst_n=1.
- Reset asserted mid-stream discards any in-flight result. out_valid stays 0 until a new in_valid is seen after release.
- X/Z on a/b propagates per standard Verilog semantics. No masking is applied.

Optional Feature:
- Macro HALF_SUB_BORROW_CNT_EN.
- When defined: adds output borrow_cnt [CNT_W-1:0].
  - On each rising edge with in_valid=1 and any bit of (~a&b) set, the counter increments by 1.
  - It saturates at all-ones and does not wrap.
  - It is asynchronously reset to 0 by rst_n=0.
- When undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the default WIDTH/CNT_W constants;
  - a function computing {borrow,d} for one lane, reused by a future full_subtractor.
- One natural sub-module: half_subtractor_lane. It is the 1-bit combinational cell, instantiated WIDTH times via generate. Registers and the counter live in the top.

Test Plan:
- WIDTH=1, no clock:
  - drive (a,b)=(0,0),(0,1),(1,0),(1,1), each held 50 time units;
  - required (d,borrow) = (0,0),(1,1),(1,0),(0,0), settled within each interval.
- Registered path: rst_n released, in_valid=1 with a=1,b=0 at edge N -> d_q=1, borrow_q=0, out_valid=1 after edge N; then in_valid=0 -> out_valid=0, d_q stays 1.
- Async reset: mid-stream, pulse rst_n low between edges -> d_q, borrow_q, out_valid read 0 immediately; d/borrow still track a/b.
- WIDTH=4: a=4'b1010, b=4'b0110 -> d=4'b1100, borrow=4'b0100; registered copy is identical one cycle later.
- With HALF_SUB_BORROW_CNT_EN and CNT_W=2: five valid borrowing inputs (a=0,b=1) -> borrow_cnt goes 1,2,3,3,3 (saturates); a non-borrowing valid (1,0) leaves it unchanged.
